// File: rtl/acc_seq_pkg.sv
// Shared types and default constants for the accumulator data-out stage sequencer.
package acc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_GAP,
    S_DONE
  } acc_seq_state_t;

  localparam int unsigned DEF_MAX_STAGES = 16;
  localparam int unsigned DEF_GAP_CYCLES = 2;
  localparam int unsigned DEF_TIMEOUT    = 4096;
  localparam int unsigned DEF_CFG_W      = 32;

  // The engine may still present the previous stage's done for this many WAIT cycles.
  localparam int unsigned WDOG_DONE_MASK = 2;

endpackage

// File: rtl/acc_cfg_regfile.sv
// Per-stage config table: host write port locked while a job runs, registered read port.
module acc_cfg_regfile #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CFG_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     busy,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [CFG_W-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [CFG_W-1:0]         rd_data
);

  logic [CFG_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && !busy) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/acc_out_stage_sequencer.sv
// Steps the data-out transfer engine through a multi-stage job with a start/done
// handshake per stage, a guard gap between stages, a watchdog and an abort path.
module acc_out_stage_sequencer
  import acc_seq_pkg::*;
#(
  parameter int unsigned MAX_STAGES = DEF_MAX_STAGES,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned CFG_W      = DEF_CFG_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_wr_en,
  input  logic [$clog2(MAX_STAGES)-1:0] cfg_wr_idx,
  input  logic [CFG_W-1:0]              cfg_wr_data,
  input  logic                          job_valid,
  output logic                          job_ready,
  input  logic [$clog2(MAX_STAGES):0]   job_num_stages,
  input  logic                          abort,
  output logic                          stage_start,
  output logic [CFG_W-1:0]              configs,
  input  logic                          stage_done,
  output logic [$clog2(MAX_STAGES)-1:0] stage_idx,
  output logic                          busy,
  output logic                          job_done,
  output logic                          timeout_err
);

  localparam int unsigned IW = $clog2(MAX_STAGES);
  localparam int unsigned NW = IW + 1;
  localparam int unsigned WW = $clog2(TIMEOUT);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  acc_seq_state_t state_q, state_d;
  logic           start_q, start_d;
  logic [WW-1:0]  wdog_q, wdog_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [NW-1:0]  n_q, n_d, n_clamp;
  logic           done_d, tmo_d;
  logic           rd_en;
  logic [IW-1:0]  rd_idx;

  assign n_clamp = (job_num_stages > NW'(MAX_STAGES)) ? NW'(MAX_STAGES) : job_num_stages;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      wdog_q      <= '0;
      gap_q       <= '0;
      idx_q       <= '0;
      n_q         <= '0;
      job_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      wdog_q      <= wdog_d;
      gap_q       <= gap_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      job_done    <= done_d;
      timeout_err <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    wdog_d  = wdog_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    n_d     = n_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    rd_en   = 1'b0;
    rd_idx  = idx_q + IW'(1);
    // Abort outranks every in-state transition, including done and watchdog.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      start_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (job_valid && !abort) begin
            n_d   = n_clamp;
            idx_d = '0;
            if (n_clamp == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              rd_en   = 1'b1;
              rd_idx  = '0;
              state_d = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          start_d = 1'b1;
          wdog_d  = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (stage_done && wdog_q >= WW'(WDOG_DONE_MASK)) begin
            start_d = 1'b0;
            gap_d   = '0;
            state_d = S_GAP;
          end else if (wdog_q == WW'(TIMEOUT - 1)) begin
            start_d = 1'b0;
            tmo_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            wdog_d = wdog_q + WW'(1);
          end
        end
        S_GAP: begin
          if (gap_q == GW'(GAP_CYCLES - 1)) begin
            if (NW'(idx_q) + NW'(1) == n_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + IW'(1);
              rd_en   = 1'b1;
              state_d = S_LOAD;
            end
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  acc_cfg_regfile #(
    .DEPTH(MAX_STAGES),
    .CFG_W(CFG_W)
  ) u_cfg_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .busy    (busy),
    .wr_en   (cfg_wr_en),
    .wr_idx  (cfg_wr_idx),
    .wr_data (cfg_wr_data),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_data (configs)
  );

  assign stage_start = start_q;
  assign stage_idx   = idx_q;
  assign busy        = (state_q != S_IDLE);
  assign job_ready   = (state_q == S_IDLE);

endmodule
